// File: rtl/wb_arbiter_2m_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
package wb_arbiter_2m_pkg;

  // Arbiter FSM states: nobody granted, master 0 granted, master 1 granted.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_t;

  // Master index constants, also the encoding of the last-grant register.
  localparam logic MST0 = 1'b0;
  localparam logic MST1 = 1'b1;

  // Round-robin pick from IDLE: a lone requester wins; on a tie the master
  // that was not granted last wins.
  function automatic logic grant_pick(input logic cyc0, input logic cyc1,
                                      input logic last);
    logic pick;
    if (cyc0 && cyc1) begin
      pick = ~last;
    end else if (cyc0) begin
      pick = MST0;
    end else begin
      pick = MST1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/wb_arbiter_2m_if.sv
// Wishbone classic bus bundle: one master-side view and one slave-side view.
// err and gnt carry the arbiter's watchdog error and bus-ownership indication.
interface wb_arbiter_2m_if #(
  parameter int ADR_W = 16,
  parameter int DAT_W = 32
);
  logic             cyc;
  logic             stb;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_w;
  logic [DAT_W-1:0] dat_r;
  logic             ack;
  logic             err;
  logic             gnt;

  modport master (
    output cyc, stb, we, adr, dat_w,
    input  dat_r, ack, err, gnt
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w,
    output dat_r, ack, err, gnt
  );
endinterface

// File: rtl/wb_arbiter_2m_watchdog.sv
// Stall watchdog: counts consecutive strobed-but-unacknowledged cycles and
// flags the TIMEOUT-th one. The counter saturates and never wraps.
module wb_arbiter_2m_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] wd_cnt;

  // Stall counter: clear has priority, then a saturating increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (clear) begin
      wd_cnt <= '0;
    end else if (enable && (wd_cnt != CNT_MAX)) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end else begin
      wd_cnt <= wd_cnt;
    end
  end

  // The flagged cycle is the one whose stall would be the TIMEOUT-th.
  assign timeout = enable && (wd_cnt == LAST_CNT);

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone classic arbiter. Round-robin grant held for
// the whole CYC, one-cycle arbitration latency, watchdog-terminated stalls.
module wb_arbiter_2m
  import wb_arbiter_2m_pkg::*;
#(
  parameter int ADR_W   = 16,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst,
  wb_arbiter_2m_if.slave  m0,
  wb_arbiter_2m_if.slave  m1,
  wb_arbiter_2m_if.master s
);
  arb_state_t state_r;
  arb_state_t state_nxt;
  logic       last_r;
  logic       gnt0;
  logic       gnt1;
  logic       wd_timeout;
  logic       wd_enable;
  logic       wd_clear;

  logic             mux_cyc;
  logic             mux_stb;
  logic             mux_we;
  logic [ADR_W-1:0] mux_adr;
  logic [DAT_W-1:0] mux_dat;

  // State and last-grant registers; last follows whichever master is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      last_r  <= MST1;
    end else begin
      state_r <= state_nxt;
      if (state_nxt == ST_GNT0) begin
        last_r <= MST0;
      end else if (state_nxt == ST_GNT1) begin
        last_r <= MST1;
      end else begin
        last_r <= last_r;
      end
    end
  end

  // Next-state: no preemption; on release hand straight over if the other
  // master is waiting; a watchdog timeout always drops back to IDLE.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (m0.cyc || m1.cyc) begin
          state_nxt = (grant_pick(m0.cyc, m1.cyc, last_r) == MST0) ? ST_GNT0 : ST_GNT1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_GNT0: begin
        if (wd_timeout) begin
          state_nxt = ST_IDLE;
        end else if (!m0.cyc) begin
          state_nxt = m1.cyc ? ST_GNT1 : ST_IDLE;
        end else begin
          state_nxt = ST_GNT0;
        end
      end
      ST_GNT1: begin
        if (wd_timeout) begin
          state_nxt = ST_IDLE;
        end else if (!m1.cyc) begin
          state_nxt = m0.cyc ? ST_GNT0 : ST_IDLE;
        end else begin
          state_nxt = ST_GNT1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign gnt0 = (state_r == ST_GNT0);
  assign gnt1 = (state_r == ST_GNT1);

  // Slave-side mux, gated by the registered grant so reset silences it at once.
  always_comb begin
    mux_cyc = 1'b0;
    mux_stb = 1'b0;
    mux_we  = 1'b0;
    mux_adr = '0;
    mux_dat = '0;
    if (gnt0) begin
      mux_cyc = m0.cyc;
      mux_stb = m0.stb;
      mux_we  = m0.we;
      mux_adr = m0.adr;
      mux_dat = m0.dat_w;
    end else if (gnt1) begin
      mux_cyc = m1.cyc;
      mux_stb = m1.stb;
      mux_we  = m1.we;
      mux_adr = m1.adr;
      mux_dat = m1.dat_w;
    end else begin
      mux_cyc = 1'b0;
    end
  end

  assign s.cyc   = mux_cyc;
  assign s.stb   = mux_stb;
  assign s.we    = mux_we;
  assign s.adr   = mux_adr;
  assign s.dat_w = mux_dat;

  // Return path: read data broadcast, ack/err only to the owner.
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;
  assign m0.ack   = gnt0 & s.ack;
  assign m1.ack   = gnt1 & s.ack;
  assign m0.err   = gnt0 & wd_timeout;
  assign m1.err   = gnt1 & wd_timeout;
  assign m0.gnt   = gnt0;
  assign m1.gnt   = gnt1;

  // A stall is a strobe without ack; any gap, ack or ownership change restarts.
  assign wd_enable = mux_stb & ~s.ack;
  assign wd_clear  = ~wd_enable | (state_nxt != state_r);

  generate
    if (TIMEOUT > 0) begin : g_wd
      wb_arbiter_2m_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .timeout (wd_timeout)
      );
    end else begin : g_no_wd
      assign wd_timeout = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed self-checking bench for wb_arbiter_2m (plus a TIMEOUT=0 build).
module tb_wb_arbiter_2m;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m_if #(.ADR_W(16), .DAT_W(32)) m0_bus ();
  wb_arbiter_2m_if #(.ADR_W(16), .DAT_W(32)) m1_bus ();
  wb_arbiter_2m_if #(.ADR_W(16), .DAT_W(32)) s_bus ();
  wb_arbiter_2m_if #(.ADR_W(16), .DAT_W(32)) nt_m0 ();
  wb_arbiter_2m_if #(.ADR_W(16), .DAT_W(32)) nt_m1 ();
  wb_arbiter_2m_if #(.ADR_W(16), .DAT_W(32)) nt_s ();

  wb_arbiter_2m #(.ADR_W(16), .DAT_W(32), .TIMEOUT(16)) dut (
    .clk (clk), .rst (rst), .m0 (m0_bus), .m1 (m1_bus), .s (s_bus)
  );

  wb_arbiter_2m #(.ADR_W(16), .DAT_W(32), .TIMEOUT(0)) dut_nt (
    .clk (clk), .rst (rst), .m0 (nt_m0), .m1 (nt_m1), .s (nt_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; inputs change here, checks follow #1.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic m0_drive(input logic cyc, input logic we, input logic [15:0] adr, input logic [31:0] dat);
    m0_bus.cyc = cyc; m0_bus.stb = cyc; m0_bus.we = we; m0_bus.adr = adr; m0_bus.dat_w = dat;
  endtask

  task automatic m1_drive(input logic cyc, input logic we, input logic [15:0] adr, input logic [31:0] dat);
    m1_bus.cyc = cyc; m1_bus.stb = cyc; m1_bus.we = we; m1_bus.adr = adr; m1_bus.dat_w = dat;
  endtask

  initial begin
    m0_drive(1'b1, 1'b1, 16'h1111, 32'h0);
    m1_drive(1'b0, 1'b0, 16'h0, 32'h0);
    s_bus.ack = 1'b1; s_bus.dat_r = 32'h0; s_bus.err = 1'b0; s_bus.gnt = 1'b0;
    nt_m0.cyc = 1'b1; nt_m0.stb = 1'b1; nt_m0.we = 1'b0; nt_m0.adr = 16'h0; nt_m0.dat_w = 32'h0;
    nt_m1.cyc = 1'b0; nt_m1.stb = 1'b0; nt_m1.we = 1'b0; nt_m1.adr = 16'h0; nt_m1.dat_w = 32'h0;
    nt_s.ack = 1'b0; nt_s.dat_r = 32'h0; nt_s.err = 1'b0; nt_s.gnt = 1'b0;

    // Reset state: request and slave ack present, but everything held low.
    #1;
    chk("rst_gnt0", m0_bus.gnt, 1'b0);
    chk("rst_gnt1", m1_bus.gnt, 1'b0);
    chk("rst_scyc", s_bus.cyc, 1'b0);
    chk("rst_sstb", s_bus.stb, 1'b0);
    chk("rst_ack0", m0_bus.ack, 1'b0);
    step(); step();

    // Test 2: both request on the first cycle after reset -> m0 (last=1).
    rst = 1'b0; s_bus.ack = 1'b0;
    m0_drive(1'b1, 1'b0, 16'h4100, 32'h0);
    m1_drive(1'b1, 1'b0, 16'h4200, 32'h0);
    #1;
    chk("t2_lat_gnt0", m0_bus.gnt, 1'b0);
    chk("t2_lat_gnt1", m1_bus.gnt, 1'b0);
    step(); s_bus.ack = 1'b1; s_bus.dat_r = 32'hA5A5_0001; #1;
    chk("t2_gnt0", m0_bus.gnt, 1'b1);
    chk("t2_gnt1_lo", m1_bus.gnt, 1'b0);
    chk("t2_sadr0", s_bus.adr, 32'h4100);
    chk("t2_ack0", m0_bus.ack, 1'b1);
    chk("t2_ack1_lo", m1_bus.ack, 1'b0);
    step(); s_bus.ack = 1'b0; m0_drive(1'b0, 1'b0, 16'h0, 32'h0); #1;
    chk("t2_rel_gnt0", m0_bus.gnt, 1'b1);
    chk("t2_rel_scyc", s_bus.cyc, 1'b0);
    step(); s_bus.ack = 1'b1; s_bus.dat_r = 32'h5A5A_0002; #1;
    chk("t2_gnt1", m1_bus.gnt, 1'b1);
    chk("t2_sadr1", s_bus.adr, 32'h4200);
    chk("t2_ack1", m1_bus.ack, 1'b1);
    chk("t2_ack0_lo", m0_bus.ack, 1'b0);
    chk("t2_dat1", m1_bus.dat_r, 32'h5A5A_0002);
    chk("t2_dat0_bcast", m0_bus.dat_r, 32'h5A5A_0002);
    step(); s_bus.ack = 1'b0; m1_drive(1'b0, 1'b0, 16'h0, 32'h0);
    step(); #1;
    chk("t2_idle_gnt1", m1_bus.gnt, 1'b0);
    m0_drive(1'b1, 1'b0, 16'h4100, 32'h0);
    m1_drive(1'b1, 1'b0, 16'h4200, 32'h0);
    step(); step(); #1;
    chk("t2_alt_gnt0", m0_bus.gnt, 1'b1);
    chk("t2_alt_gnt1", m1_bus.gnt, 1'b0);
    m0_drive(1'b0, 1'b0, 16'h0, 32'h0);
    m1_drive(1'b0, 1'b0, 16'h0, 32'h0);
    step(); step();

    // Test 1: m0 single write.
    m0_drive(1'b1, 1'b1, 16'h400A, 32'h0000_0064); #1;
    chk("t1_lat_gnt0", m0_bus.gnt, 1'b0);
    chk("t1_lat_scyc", s_bus.cyc, 1'b0);
    step(); s_bus.ack = 1'b1; #1;
    chk("t1_gnt0", m0_bus.gnt, 1'b1);
    chk("t1_swe", s_bus.we, 1'b1);
    chk("t1_sadr", s_bus.adr, 32'h400A);
    chk("t1_sdat", s_bus.dat_w, 32'h64);
    chk("t1_ack0", m0_bus.ack, 1'b1);
    chk("t1_ack1_lo", m1_bus.ack, 1'b0);
    step(); s_bus.ack = 1'b0; m0_drive(1'b0, 1'b0, 16'h0, 32'h0);
    step(); #1;
    chk("t1_end_gnt0", m0_bus.gnt, 1'b0);
    chk("t1_end_sadr", s_bus.adr, 32'h0);

    // Test 3: m0 4-read burst while m1 waits.
    m0_drive(1'b1, 1'b0, 16'h4000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) m1_drive(1'b1, 1'b0, 16'h4300, 32'h0);
      m0_bus.adr = 16'h4000 + 16'(i);
      s_bus.ack = 1'b1; s_bus.dat_r = 32'hD000 + 32'(i);
      #1;
      chk("t3_sadr", s_bus.adr, 32'h4000 + 32'(i));
      chk("t3_ack0", m0_bus.ack, 1'b1);
      chk("t3_dat0", m0_bus.dat_r, 32'hD000 + 32'(i));
      chk("t3_gnt1_lo", m1_bus.gnt, 1'b0);
      chk("t3_ack1_lo", m1_bus.ack, 1'b0);
    end
    step(); s_bus.ack = 1'b0; m0_drive(1'b0, 1'b0, 16'h0, 32'h0); #1;
    chk("t3_rel_gnt1", m1_bus.gnt, 1'b0);
    chk("t3_rel_scyc", s_bus.cyc, 1'b0);
    step(); #1;
    chk("t3_gnt1", m1_bus.gnt, 1'b1);
    chk("t3_scyc1", s_bus.cyc, 1'b1);
    m1_drive(1'b0, 1'b0, 16'h0, 32'h0);
    step(); step();

    // Test 4: slave never acks -> ERR on the 16th stalled cycle.
    m0_drive(1'b1, 1'b0, 16'h4010, 32'h0);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1) m1_drive(1'b1, 1'b0, 16'h4020, 32'h0);
      #1;
      chk($sformatf("t4_err0_c%0d", k), m0_bus.err, (k == 16) ? 32'd1 : 32'd0);
      chk("t4_gnt0", m0_bus.gnt, 1'b1);
      chk("t4_err1_lo", m1_bus.err, 1'b0);
      chk("t4_nt_gnt0", nt_m0.gnt, 1'b1);
      chk("t4_nt_err0", nt_m0.err, 1'b0);
    end
    step(); #1;
    chk("t4_idle_gnt0", m0_bus.gnt, 1'b0);
    chk("t4_idle_gnt1", m1_bus.gnt, 1'b0);
    chk("t4_idle_err0", m0_bus.err, 1'b0);
    step(); #1;
    chk("t4_m1_gnt", m1_bus.gnt, 1'b1);
    chk("t4_m1_gnt0_lo", m0_bus.gnt, 1'b0);
    chk("t4_nt_err_late", nt_m0.err, 1'b0);
    m0_drive(1'b0, 1'b0, 16'h0, 32'h0);
    m1_drive(1'b0, 1'b0, 16'h0, 32'h0);
    step(); step();

    // Test 6: ack arrives on the 16th stalled cycle -> no ERR, grant kept.
    m0_drive(1'b1, 1'b0, 16'h4030, 32'h0);
    for (int k = 1; k <= 17; k++) begin
      step();
      s_bus.ack = (k == 16);
      #1;
      if (k >= 15) begin
        chk($sformatf("t6_err0_c%0d", k), m0_bus.err, 1'b0);
        chk($sformatf("t6_ack0_c%0d", k), m0_bus.ack, (k == 16) ? 32'd1 : 32'd0);
        chk($sformatf("t6_gnt0_c%0d", k), m0_bus.gnt, 1'b1);
      end
    end
    step(); s_bus.ack = 1'b0; m0_drive(1'b0, 1'b0, 16'h0, 32'h0);
    step(); step();

    // Test 5: asynchronous reset mid-burst, then last=1 rule after release.
    m0_drive(1'b1, 1'b1, 16'h4040, 32'h77);
    step(); #1;
    chk("t5_gnt0_pre", m0_bus.gnt, 1'b1);
    #1; rst = 1'b1; #1;
    chk("t5_async_gnt0", m0_bus.gnt, 1'b0);
    chk("t5_async_scyc", s_bus.cyc, 1'b0);
    chk("t5_async_sstb", s_bus.stb, 1'b0);
    chk("t5_async_swe", s_bus.we, 1'b0);
    step(); m1_drive(1'b1, 1'b0, 16'h4050, 32'h0);
    step(); rst = 1'b0; #1;
    chk("t5_rel_gnt0", m0_bus.gnt, 1'b0);
    chk("t5_rel_gnt1", m1_bus.gnt, 1'b0);
    step(); #1;
    chk("t5_regnt0", m0_bus.gnt, 1'b1);
    chk("t5_regnt1_lo", m1_bus.gnt, 1'b0);
    chk("t5_sadr", s_bus.adr, 32'h4040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
